// File: rtl/playback_sequencer.sv
`default_nettype none
// playback_sequencer: launches a playback unit, primes its FIFO, generates the
// bit tick from a programmable divider and services FIFO advance requests.
module playback_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] cfgRequestNum,
  input  logic [15:0] cfgBitDiv,
  input  logic        fifoEmpty,
  input  logic        unitAdvFIFO,
  input  logic        unitComplete,
  output logic        unitResetN,
  output logic        unitEnable,
  output logic        unitPlaybackClk,
  output logic [15:0] unitRequestNum,
  output logic        fifoRdEn,
  output logic        busy,
  output logic        done,
  output logic        underrun,
  output logic [23:0] tickCount
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRIME = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [15:0] divisor;
  logic [15:0] div_cnt;
  logic [15:0] div_nxt;
  logic        adv_q;
  logic        adv_rise;
  logic        start_ok;
  logic        pop_nxt;
  logic        tick_nxt;

  always_comb begin
    adv_rise  = unitAdvFIFO & ~adv_q;
    start_ok  = 1'b0;
    state_nxt = state;
    pop_nxt   = 1'b0;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            start_ok  = 1'b1;
            state_nxt = S_PRIME;
          end
        end
        S_PRIME: begin
          if (!fifoEmpty) begin
            state_nxt = S_RUN;
            pop_nxt   = 1'b1;
          end
        end
        S_RUN: begin
          // completion wins over a coincident advance edge
          if (unitComplete) begin
            state_nxt = S_DONE;
          end else if (adv_rise) begin
            if (fifoEmpty) state_nxt = S_ERR;
            else           pop_nxt   = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Divider restarts at 0 on RUN entry, so the first tick lands on RUN cycle 'divisor'.
  always_comb begin
    if (state != S_RUN)                div_nxt = 16'd0;
    else if (div_cnt == divisor - 16'd1) div_nxt = 16'd0;
    else                               div_nxt = div_cnt + 16'd1;
    tick_nxt = (state_nxt == S_RUN) && (div_nxt == divisor - 16'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      divisor         <= 16'd0;
      div_cnt         <= 16'd0;
      adv_q           <= 1'b0;
      unitResetN      <= 1'b0;
      unitEnable      <= 1'b0;
      unitPlaybackClk <= 1'b0;
      unitRequestNum  <= 16'd0;
      fifoRdEn        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      underrun        <= 1'b0;
      tickCount       <= 24'd0;
    end else begin
      state           <= state_nxt;
      div_cnt         <= div_nxt;
      adv_q           <= unitAdvFIFO;
      fifoRdEn        <= pop_nxt;
      unitPlaybackClk <= tick_nxt;
      busy            <= (state_nxt == S_PRIME) || (state_nxt == S_RUN);
      unitResetN      <= (state_nxt == S_PRIME) || (state_nxt == S_RUN);
      unitEnable      <= (state_nxt == S_RUN);
      done            <= (state_nxt == S_DONE);
      underrun        <= (state_nxt == S_ERR);
      if (start_ok) begin
        unitRequestNum <= cfgRequestNum;
        divisor        <= (cfgBitDiv < 16'd2) ? 16'd2 : cfgBitDiv;
        tickCount      <= 24'd0;
      end else if (tick_nxt && (tickCount != 24'hFFFFFF)) begin
        tickCount <= tickCount + 24'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_playback_sequencer.sv
`default_nettype none
// tb_playback_sequencer: table-driven directed vectors plus a mid-RUN reset sequence.
module tb_playback_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort, fifoEmpty, unitAdvFIFO, unitComplete;
  logic [15:0] cfgRequestNum, cfgBitDiv;
  logic        unitResetN, unitEnable, unitPlaybackClk, fifoRdEn, busy, done, underrun;
  logic [15:0] unitRequestNum;
  logic [23:0] tickCount;

  int checks = 0;
  int failures = 0;

  playback_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfgRequestNum(cfgRequestNum), .cfgBitDiv(cfgBitDiv),
    .fifoEmpty(fifoEmpty), .unitAdvFIFO(unitAdvFIFO), .unitComplete(unitComplete),
    .unitResetN(unitResetN), .unitEnable(unitEnable), .unitPlaybackClk(unitPlaybackClk),
    .unitRequestNum(unitRequestNum), .fifoRdEn(fifoRdEn), .busy(busy), .done(done),
    .underrun(underrun), .tickCount(tickCount)
  );

  always #5 clk = ~clk;

  // flags = {busy, done, underrun, unitResetN, unitEnable, unitPlaybackClk, fifoRdEn}
  localparam logic [6:0] PR = 7'b1001000;
  localparam logic [6:0] RN = 7'b1001100;
  localparam logic [6:0] RD = 7'b1001101;
  localparam logic [6:0] TK = 7'b1001110;
  localparam logic [6:0] DN = 7'b0100000;
  localparam logic [6:0] ER = 7'b0010000;
  localparam logic [6:0] ID = 7'b0000000;

  typedef struct {
    logic        st, ab;
    logic [15:0] dv, rq;
    logic        fe, adv, cmp;
    logic [6:0]  fl;
    logic [23:0] tc;
    logic [15:0] rqo;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [6:0] flags();
    return {busy, done, underrun, unitResetN, unitEnable, unitPlaybackClk, fifoRdEn};
  endfunction

  task automatic add(input logic st, ab, input logic [15:0] dv, rq,
                     input logic fe, adv, cmp, input logic [6:0] fl,
                     input logic [23:0] tc, input logic [15:0] rqo);
    vec_t v;
    v.st = st; v.ab = ab; v.dv = dv; v.rq = rq; v.fe = fe; v.adv = adv; v.cmp = cmp;
    v.fl = fl; v.tc = tc; v.rqo = rqo;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; fifoEmpty = 1'b1;
    unitAdvFIFO = 1'b0; unitComplete = 1'b0;
    cfgRequestNum = 16'h0; cfgBitDiv = 16'h0;

    // divisor 4: PRIME, RUN with ticks on RUN cycles 4, 8, ...
    add(1,0,16'd4,16'h0001,0,0,0, PR,0,16'h0001);
    add(0,0,16'd7,16'h0F0F,0,0,0, RD,0,16'h0001);
    add(0,0,16'd7,16'h0F0F,0,0,0, RN,0,16'h0001);
    add(0,0,16'd7,16'h0F0F,0,0,0, RN,0,16'h0001);
    add(0,0,16'd7,16'h0F0F,0,0,0, TK,1,16'h0001);
    add(0,0,16'd7,16'h0F0F,0,0,0, RN,1,16'h0001);
    add(0,0,16'd7,16'h0F0F,0,0,0, RN,1,16'h0001);
    add(0,0,16'd7,16'h0F0F,0,0,0, RN,1,16'h0001);
    add(0,0,16'd7,16'h0F0F,0,0,0, TK,2,16'h0001);
    // advance held high for 10 cycles: a single pop
    add(0,0,16'd7,16'h0F0F,0,1,0, RD,2,16'h0001);
    add(0,0,16'd7,16'h0F0F,0,1,0, RN,2,16'h0001);
    add(0,0,16'd7,16'h0F0F,0,1,0, RN,2,16'h0001);
    add(0,0,16'd7,16'h0F0F,0,1,0, TK,3,16'h0001);
    add(0,0,16'd7,16'h0F0F,0,1,0, RN,3,16'h0001);
    add(0,0,16'd7,16'h0F0F,0,1,0, RN,3,16'h0001);
    add(0,0,16'd7,16'h0F0F,0,1,0, RN,3,16'h0001);
    add(0,0,16'd7,16'h0F0F,0,1,0, TK,4,16'h0001);
    add(0,0,16'd7,16'h0F0F,0,1,0, RN,4,16'h0001);
    add(0,0,16'd7,16'h0F0F,0,1,0, RN,4,16'h0001);
    add(0,0,16'd7,16'h0F0F,0,0,0, RN,4,16'h0001);
    // advance on empty FIFO in the cycle a tick was due: ERR, no tick
    add(0,0,16'd7,16'h0F0F,1,1,0, ER,4,16'h0001);
    // restart from ERR with divisor 0 (acts as 2), PRIME waits for data
    add(1,0,16'd0,16'h0005,1,0,0, PR,0,16'h0005);
    add(0,0,16'd7,16'h0F0F,1,0,0, PR,0,16'h0005);
    add(0,0,16'd7,16'h0F0F,0,0,0, RD,0,16'h0005);
    add(0,0,16'd7,16'h0F0F,0,0,0, TK,1,16'h0005);
    add(0,0,16'd7,16'h0F0F,0,0,0, RN,1,16'h0005);
    add(0,0,16'd7,16'h0F0F,0,0,0, TK,2,16'h0005);
    // complete with coincident advance edge: DONE, no pop
    add(0,0,16'd7,16'h0F0F,0,1,1, DN,2,16'h0005);
    // restart from DONE with divisor 1 (acts as 2)
    add(1,0,16'd1,16'hABCD,0,0,0, PR,0,16'hABCD);
    add(0,0,16'd7,16'h0F0F,0,0,0, RD,0,16'hABCD);
    // start in RUN is ignored
    add(1,0,16'd7,16'h0F0F,0,0,0, TK,1,16'hABCD);
    // abort beats start
    add(1,1,16'd7,16'h0F0F,0,0,0, ID,1,16'hABCD);
    add(0,0,16'd7,16'h0F0F,0,0,0, ID,1,16'hABCD);

    step();
    step();
    chk("reset flags", 32'(flags()), 32'(ID));
    chk("reset tickCount", 32'(tickCount), 32'd0);
    chk("reset reqnum", 32'(unitRequestNum), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      start = vecs[i].st; abort = vecs[i].ab;
      cfgBitDiv = vecs[i].dv; cfgRequestNum = vecs[i].rq;
      fifoEmpty = vecs[i].fe; unitAdvFIFO = vecs[i].adv; unitComplete = vecs[i].cmp;
      step();
      chk($sformatf("v%0d flags", i), 32'(flags()), 32'(vecs[i].fl));
      chk($sformatf("v%0d tickCount", i), 32'(tickCount), 32'(vecs[i].tc));
      chk($sformatf("v%0d reqnum", i), 32'(unitRequestNum), 32'(vecs[i].rqo));
    end

    // reset asserted during RUN cycle 3 with divisor 4: the due tick must not appear
    @(negedge clk);
    start = 1'b1; cfgBitDiv = 16'd4; cfgRequestNum = 16'h1234; fifoEmpty = 1'b0;
    unitAdvFIFO = 1'b0; unitComplete = 1'b0; abort = 1'b0;
    step();
    chk("rst seq prime", 32'(flags()), 32'(PR));
    @(negedge clk);
    start = 1'b0;
    step();
    chk("rst seq run1", 32'(flags()), 32'(RD));
    step();
    step();
    chk("rst seq run3", 32'(flags()), 32'(RN));
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("midrun reset flags", 32'(flags()), 32'(ID));
    chk("midrun reset tickCount", 32'(tickCount), 32'd0);
    chk("midrun reset reqnum", 32'(unitRequestNum), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("post reset idle flags", 32'(flags()), 32'(ID));
    chk("post reset tickCount", 32'(tickCount), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
